ibex_prefetch_ctrl: RTL and testbench
=====================================

Name: ibex_prefetch_ctrl

Overview:
Instruction-side bus master that feeds the fetch FIFO.
- Issues word-aligned fetch requests on the instruction memory bus (req/gnt/rvalid) with up to NUM_REQS requests outstanding.
- Throttles requests against FIFO occupancy and discards responses made stale by a branch.
- Pushes surviving responses into the FIFO and drives the FIFO clear/branch-address on redirect.
- Sits between the IF-stage controller and the fetch FIFO.

Parameters:
NUM_REQS, 2, maximum outstanding bus requests; must equal the fetch FIFO's NUM_REQS (width of its busy vector).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  fetch enable from IF controller
branch_i  in  1  redirect fetch to addr_i this cycle
addr_i  in  32  branch target (halfword aligned)
busy_o  out  1  request pending or response outstanding
fifo_clear_o  out  1  clear to fetch FIFO
fifo_busy_i  in  NUM_REQS  upper-entry occupancy from fetch FIFO
fifo_valid_o  out  1  push one word into FIFO
fifo_addr_o  out  32  branch target handed to FIFO on clear
fifo_rdata_o  out  32  pushed word
fifo_err_o  out  1  pushed word bus error
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus word address, bits [1:0] = 0
instr_rvalid_i  in  1  bus response valid, in order
instr_rdata_i  in  32  bus response data
instr_err_i  in  1  bus response error

Behaviour:
- Reset: instr_req_o=0, fifo_valid_o=0, busy_o=0, all outstanding/discard bits=0, fetch_addr_q=0, FSM=IDLE.
- Clear path (combinational, zero latency): fifo_clear_o = branch_i; fifo_addr_o = addr_i.
- Fetch address:
  - On branch, fetch_addr_q := {addr_i[31:2],2'b00}.
  - Each granted non-branch-superseded request advances fetch_addr_q by 4; wraps modulo 2^32.
- Issue condition new_req = req_i & slot_free & (fifo_room | branch_i).
  - slot_free = outstanding count < NUM_REQS.
  - fifo_room = (outstanding count + popcount(fifo_busy_i)) < NUM_REQS.
- FSM with two states:
  - IDLE: instr_req_o = new_req. instr_addr_o = branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q. On req without gnt, latch the address into stored_addr_q and go to WAIT_GNT.
  - WAIT_GNT: instr_req_o=1 and instr_addr_o=stored_addr_q, held stable regardless of req_i or branch_i. On gnt, return to IDLE.
  - A branch in WAIT_GNT marks the pending request for discard and records the target. The target is issued from IDLE in the cycle after gnt.
  - Same-cycle gnt and new_req in WAIT_GNT: no back-to-back issue. The next request is issued from IDLE in the following cycle.
- Outstanding tracking: in-order shift registers rdata_outstanding_q[NUM_REQS-1:0] and discard_q[NUM_REQS-1:0].
  - On gnt, set the lowest free bit.
  - On rvalid, shift down by one.
  - gnt and rvalid in the same cycle apply both, with net count unchanged.
- Branch sets discard_q for all currently outstanding entries. The request granted in the same cycle as branch_i is also discarded, unless it is the branch-target request itself issued from IDLE.
- Response: fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i. fifo_rdata_o and fifo_err_o pass instr_rdata_i and instr_err_i through with zero latency. Discarded responses are consumed silently.
- rvalid with no outstanding request is a protocol violation (assertion); state is unchanged.
- busy_o = instr_req_o | (|rdata_outstanding_q).
- req_i low: no new request. Outstanding responses still complete and push.
- Reset mid-transaction: all tracking clears immediately. Any late responses after reset are ignored and trigger the assertion.

Decomposition:
- Package ibex_pkg gains:
  - the prefetch state enum (PF_IDLE, PF_WAIT_GNT);
  - the constant FETCH_WORD_INCR = 32'd4.
- No sub-module: the tracking shift registers are inline generate loops.
- The top level (ibex_prefetch_buffer wrapper) instantiates ibex_prefetch_ctrl plus ibex_fetch_fifo with matching NUM_REQS.

Test Plan:
- Reset, req_i=1, branch to 0x100, gnt always 1, rvalid 1 cycle later: instr_addr_o sequence 0x100, 0x104; no more than 2 outstanding; FIFO receives words in order with fifo_valid_o one per rvalid.
- Branch to 0x202: instr_addr_o=0x200, fifo_addr_o=0x202 with fifo_clear_o=1 in the same cycle; next request is 0x204.
- Gnt withheld 3 cycles with branch to 0x300 during the stall: instr_addr_o stays at the stalled address until gnt; that response is dropped (fifo_valid_o=0); next request is 0x300.
- Two requests outstanding, then branch: both responses are discarded; the first pushed word belongs to the branch target.
- fifo_busy_i=2'b11 with req_i=1: instr_req_o stays 0 until busy drops. A branch still issues immediately.
- gnt and rvalid in the same cycle for 20 cycles: outstanding count is stable, fetch addresses increment by 4, no data is lost, and wrap 0xFFFFFFFC to 0x0 is handled.

Source files
------------

// File: rtl/ibex_prefetch_ctrl_pkg.sv
// Shared prefetch definitions: fetch FSM states and word stride.
// Imported by the prefetch controller.
package ibex_pkg;

  typedef enum logic {
    PF_IDLE,
    PF_WAIT_GNT
  } pf_state_e;

  localparam logic [31:0] FETCH_WORD_INCR = 32'd4;

endpackage

// File: rtl/ibex_prefetch_ctrl.sv
// Instruction-side bus master feeding the fetch FIFO.
// Tracks in-order outstanding requests and drops stale responses.
module ibex_prefetch_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1) + 1;

  pf_state_e state_q, state_d;

  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] stored_addr_q, stored_addr_d;
  logic        discard_pend_q, discard_pend_d;

  logic [NUM_REQS-1:0] rdata_outstanding_q;
  logic [NUM_REQS-1:0] rdata_outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic [NUM_REQS-1:0] outs_sh, disc_sh;
  logic [NUM_REQS-1:0] free_sel;

  logic [CW-1:0] out_cnt, busy_cnt;
  logic [31:0]   branch_addr;
  logic          slot_free, fifo_room;
  logic          new_req, new_disc;
  logic          gnt_acc, rvalid_acc;

  assign branch_addr = {addr_i[31:2], 2'b00};

  always_comb begin
    out_cnt  = '0;
    busy_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      out_cnt  = out_cnt + CW'(rdata_outstanding_q[i]);
      busy_cnt = busy_cnt + CW'(fifo_busy_i[i]);
    end
  end

  assign slot_free = out_cnt < CW'(NUM_REQS);
  assign fifo_room = (out_cnt + busy_cnt) < CW'(NUM_REQS);
  assign new_req   = req_i & slot_free
                   & (fifo_room | branch_i);

  always_comb begin
    state_d        = state_q;
    fetch_addr_d   = fetch_addr_q;
    stored_addr_d  = stored_addr_q;
    discard_pend_d = discard_pend_q;
    instr_req_o    = 1'b0;
    instr_addr_o   = fetch_addr_q;
    new_disc       = 1'b0;
    unique case (state_q)
      PF_IDLE: begin
        instr_req_o  = new_req;
        instr_addr_o = branch_i ? branch_addr
                                : fetch_addr_q;
        if (branch_i) begin
          fetch_addr_d = branch_addr;
        end
        if (new_req) begin
          if (instr_gnt_i) begin
            fetch_addr_d = instr_addr_o
                         + FETCH_WORD_INCR;
          end else begin
            stored_addr_d = instr_addr_o;
            state_d       = PF_WAIT_GNT;
          end
        end
      end
      PF_WAIT_GNT: begin
        // Bus address must stay stable until granted.
        instr_req_o  = 1'b1;
        instr_addr_o = stored_addr_q;
        new_disc     = discard_pend_q | branch_i;
        if (branch_i) begin
          fetch_addr_d   = branch_addr;
          discard_pend_d = 1'b1;
        end
        if (instr_gnt_i) begin
          state_d        = PF_IDLE;
          discard_pend_d = 1'b0;
          if (!new_disc) begin
            fetch_addr_d = stored_addr_q
                         + FETCH_WORD_INCR;
          end
        end
      end
      default: state_d = PF_IDLE;
    endcase
  end

  assign gnt_acc    = instr_req_o & instr_gnt_i;
  assign rvalid_acc = instr_rvalid_i
                    & rdata_outstanding_q[0];

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_trk
    if (i == NUM_REQS - 1) begin : g_top
      assign outs_sh[i] = rvalid_acc ? 1'b0
                        : rdata_outstanding_q[i];
      assign disc_sh[i] = rvalid_acc ? 1'b0
                        : discard_q[i];
    end else begin : g_mid
      assign outs_sh[i] = rvalid_acc
                        ? rdata_outstanding_q[i+1]
                        : rdata_outstanding_q[i];
      assign disc_sh[i] = rvalid_acc
                        ? discard_q[i+1]
                        : discard_q[i];
    end
    // Entries are contiguous from bit 0, so the
    // first zero after a one is the lowest free slot.
    if (i == 0) begin : g_lo
      assign free_sel[i] = ~outs_sh[i];
    end else begin : g_hi
      assign free_sel[i] = ~outs_sh[i] & outs_sh[i-1];
    end
    assign rdata_outstanding_d[i] = outs_sh[i]
                                  | (gnt_acc & free_sel[i]);
    assign discard_d[i] = disc_sh[i]
                        | (branch_i & outs_sh[i])
                        | (gnt_acc & free_sel[i]
                           & new_disc);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q             <= PF_IDLE;
      fetch_addr_q        <= '0;
      stored_addr_q       <= '0;
      discard_pend_q      <= 1'b0;
      rdata_outstanding_q <= '0;
      discard_q           <= '0;
    end else begin
      state_q             <= state_d;
      fetch_addr_q        <= fetch_addr_d;
      stored_addr_q       <= stored_addr_d;
      discard_pend_q      <= discard_pend_d;
      rdata_outstanding_q <= rdata_outstanding_d;
      discard_q           <= discard_d;
    end
  end

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = rvalid_acc & ~discard_q[0]
                      & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o
                      | (|rdata_outstanding_q);

  a_rvalid_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> rdata_outstanding_q[0]
  );

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Bench for ibex_prefetch_ctrl: comb vector table plus
// bus-model sequences with a response scoreboard.
module tb_ibex_prefetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, branch_i;
  logic [31:0] addr_i;
  logic        busy_o, fifo_clear_o;
  logic [1:0]  fifo_busy_i;
  logic        fifo_valid_o, fifo_err_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o;
  logic        instr_req_o, instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;

  ibex_prefetch_ctrl #(.NUM_REQS(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .busy_o         (busy_o),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_busy_i    (fifo_busy_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic        br;
    logic [31:0] addr;
    logic [1:0]  busy;
    logic        e_req;
    logic        e_clr;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    bit          stale;
  } pe_t;

  int total = 0;
  int bad   = 0;

  pe_t         pend[$];
  logic [31:0] issued[$];
  logic [31:0] pushed[$];
  bit          stalled;
  bit          stall_stale;
  logic [31:0] stall_addr;
  vec_t        vt[7];

  function automatic logic [31:0] dat(
    input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic tick(input bit rv_en);
    pe_t e;
    instr_rvalid_i = rv_en && (pend.size() > 0);
    if (instr_rvalid_i) begin
      instr_rdata_i = dat(pend[0].a);
      instr_err_i   = pend[0].a[3];
    end else begin
      instr_rdata_i = '0;
      instr_err_i   = 1'b0;
    end
    #4;
    if (instr_rvalid_i) begin
      e = pend.pop_front();
      chk("push_valid", 32'(fifo_valid_o),
          32'(!e.stale && !branch_i));
      if (fifo_valid_o) begin
        chk("push_data", fifo_rdata_o, dat(e.a));
        chk("push_err", 32'(fifo_err_o), 32'(e.a[3]));
        pushed.push_back(e.a);
      end
    end else begin
      chk("no_push", 32'(fifo_valid_o), 32'd0);
    end
    if (branch_i) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      if (stalled) stall_stale = 1'b1;
    end
    if (instr_req_o && instr_gnt_i) begin
      if (stalled)
        chk("gnt_addr", instr_addr_o, stall_addr);
      pend.push_back('{instr_addr_o,
                       stalled && stall_stale});
      issued.push_back(instr_addr_o);
      stalled     = 1'b0;
      stall_stale = 1'b0;
    end else if (instr_req_o) begin
      if (stalled) begin
        chk("stall_addr", instr_addr_o, stall_addr);
      end else begin
        stalled    = 1'b1;
        stall_addr = instr_addr_o;
      end
    end
    chk("max_outst", 32'(pend.size() <= 2), 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n;
    req_i       = 1'b0;
    branch_i    = 1'b0;
    instr_gnt_i = 1'b1;
    fifo_busy_i = 2'b00;
    n = 0;
    while ((pend.size() > 0 || stalled) && n < 10) begin
      tick(1'b1);
      n++;
    end
    chk("drain_empty", 32'(pend.size()), 32'd0);
    chk("busy_idle", 32'(busy_o), 32'd0);
  endtask

  task automatic clr_logs();
    issued.delete();
    pushed.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h0,   2'b00,
              1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 32'h0,   2'b00,
              1'b1, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0,   2'b01,
              1'b1, 1'b0, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'h0,   2'b11,
              1'b0, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b1, 32'h202, 2'b11,
              1'b1, 1'b1, 32'h200};
    vt[5] = '{1'b0, 1'b1, 32'h306, 2'b00,
              1'b0, 1'b1, 32'h304};
    vt[6] = '{1'b1, 1'b0, 32'h0,   2'b10,
              1'b1, 1'b0, 32'h0};

    stalled        = 1'b0;
    stall_stale    = 1'b0;
    stall_addr     = '0;
    rst_ni         = 1'b0;
    req_i          = 1'b0;
    branch_i       = 1'b0;
    addr_i         = '0;
    fifo_busy_i    = 2'b00;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_valid", 32'(fifo_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);

    // Combinational issue/clear table, idle and empty.
    for (int i = 0; i < 7; i++) begin
      req_i       = vt[i].req;
      branch_i    = vt[i].br;
      addr_i      = vt[i].addr;
      fifo_busy_i = vt[i].busy;
      #1;
      chk($sformatf("v%0d_req", i),
          32'(instr_req_o), 32'(vt[i].e_req));
      chk($sformatf("v%0d_clr", i),
          32'(fifo_clear_o), 32'(vt[i].e_clr));
      chk($sformatf("v%0d_addr", i),
          instr_addr_o, vt[i].e_addr);
      chk($sformatf("v%0d_faddr", i),
          fifo_addr_o, vt[i].addr);
      chk($sformatf("v%0d_busy", i),
          32'(busy_o), 32'(vt[i].e_req));
    end
    req_i       = 1'b0;
    branch_i    = 1'b0;
    addr_i      = '0;
    fifo_busy_i = 2'b00;
    @(posedge clk_i);
    #1;

    // Streaming from 0x100, response one cycle later.
    clr_logs();
    req_i       = 1'b1;
    instr_gnt_i = 1'b1;
    branch_i    = 1'b1;
    addr_i      = 32'h100;
    tick(1'b1);
    branch_i = 1'b0;
    repeat (4) tick(1'b1);
    drain();
    chk("s1_n", 32'(issued.size()), 32'd5);
    if (issued.size() >= 2) begin
      chk("s1_a0", issued[0], 32'h100);
      chk("s1_a1", issued[1], 32'h104);
    end
    chk("s1_pushed", 32'(pushed.size()),
        32'(issued.size()));
    foreach (pushed[i])
      chk("s1_order", pushed[i], issued[i]);

    // Halfword branch target.
    clr_logs();
    req_i    = 1'b1;
    branch_i = 1'b1;
    addr_i   = 32'h202;
    #1;
    chk("s2_addr", instr_addr_o, 32'h200);
    chk("s2_faddr", fifo_addr_o, 32'h202);
    chk("s2_clr", 32'(fifo_clear_o), 32'd1);
    tick(1'b1);
    branch_i = 1'b0;
    tick(1'b1);
    drain();
    if (issued.size() >= 2)
      chk("s2_next", issued[1], 32'h204);
    else
      chk("s2_n", 32'(issued.size()), 32'd2);

    // Stalled grant with a branch during the stall.
    clr_logs();
    req_i       = 1'b1;
    instr_gnt_i = 1'b0;
    tick(1'b0);
    branch_i = 1'b1;
    addr_i   = 32'h300;
    tick(1'b0);
    branch_i = 1'b0;
    tick(1'b0);
    instr_gnt_i = 1'b1;
    tick(1'b0);
    tick(1'b1);
    drain();
    chk("s3_n", 32'(issued.size()), 32'd2);
    if (issued.size() >= 2) begin
      chk("s3_stall", issued[0], 32'h208);
      chk("s3_tgt", issued[1], 32'h300);
    end
    chk("s3_npush", 32'(pushed.size()), 32'd1);
    if (pushed.size() >= 1)
      chk("s3_push", pushed[0], 32'h300);

    // Two outstanding, then branch: both dropped.
    clr_logs();
    req_i       = 1'b1;
    instr_gnt_i = 1'b1;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("s4_full", 32'(pend.size()), 32'd2);
    branch_i = 1'b1;
    addr_i   = 32'h400;
    tick(1'b0);
    branch_i = 1'b0;
    repeat (3) tick(1'b1);
    drain();
    chk("s4_has", 32'(pushed.size() > 0), 32'd1);
    if (pushed.size() > 0)
      chk("s4_first", pushed[0], 32'h400);

    // FIFO full throttles; branch still issues.
    clr_logs();
    req_i       = 1'b1;
    fifo_busy_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s5_hold", 32'(instr_req_o), 32'd0);
      tick(1'b0);
    end
    branch_i = 1'b1;
    addr_i   = 32'h500;
    #1;
    chk("s5_br_req", 32'(instr_req_o), 32'd1);
    chk("s5_br_addr", instr_addr_o, 32'h500);
    tick(1'b0);
    branch_i = 1'b0;
    #1;
    chk("s5_after", 32'(instr_req_o), 32'd0);
    fifo_busy_i = 2'b00;
    #1;
    chk("s5_rel_req", 32'(instr_req_o), 32'd1);
    chk("s5_rel_addr", instr_addr_o, 32'h504);
    tick(1'b1);
    drain();

    // Steady gnt+rvalid across the address wrap.
    clr_logs();
    req_i       = 1'b1;
    instr_gnt_i = 1'b1;
    branch_i    = 1'b1;
    addr_i      = 32'hFFFF_FFF0;
    tick(1'b1);
    branch_i = 1'b0;
    for (int i = 1; i < 20; i++) begin
      tick(1'b1);
      chk("s6_outst", 32'(pend.size()), 32'd1);
    end
    drain();
    chk("s6_n", 32'(issued.size()), 32'd20);
    foreach (issued[i])
      chk("s6_addr", issued[i],
          32'hFFFF_FFF0 + 32'(4 * i));
    chk("s6_pushed", 32'(pushed.size()),
        32'(issued.size()));

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
